// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply / restoring divide unit with a start/ready handshake.
// Define MD_DIVZERO_FAST_EN to finish divide-by-zero in one cycle.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, opnd_q, acc_hi, acc_lo;
  logic             neg_q, neg_r, ready_q;
  logic [CNT_W-1:0] cnt;

  logic               is_signed, is_div, div_zero, div_ge;
  logic [WIDTH-1:0]   a_mag, b_mag, step_hi, step_lo, quo_fix, rem_fix;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [2*WIDTH-1:0] prod_fix, fix_result;

  // acc_hi/acc_lo hold {partial product, multiplier} for mul and {remainder, quotient} for div.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    is_signed = ~op_q[0];
    is_div    = op_q[1];
    div_zero  = (b_q == '0);
    a_mag     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    b_mag     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
    rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
    div_ge  = (rem_sh >= {1'b0, opnd_q});

    if (is_div) begin
      step_hi = div_ge ? (rem_sh[WIDTH-1:0] - opnd_q) : rem_sh[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end

    prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo_fix  = neg_q ? -acc_lo : acc_lo;
    rem_fix  = neg_r ? -acc_hi : acc_hi;

    if (!is_div)       fix_result = prod_fix;
    else if (div_zero) fix_result = {a_q, {WIDTH{1'b1}}};
    else               fix_result = {rem_fix, quo_fix};
  end

  // A flush in DONE must suppress the pulse in the same cycle, hence the combinational gate.
  assign ready_o = ready_q & ~annul_i;

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!resetn) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      opnd_q   <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      cnt      <= '0;
      busy_o   <= 1'b0;
      ready_q  <= 1'b0;
      result_o <= '0;
    end else if (annul_i && state != IDLE) begin
      state   <= IDLE;
      busy_o  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !annul_i) begin
            op_q <= op_i;
            a_q  <= opdata1_i;
            b_q  <= opdata2_i;
`ifdef MD_DIVZERO_FAST_EN
            if (op_i[1] && opdata2_i == '0) begin
              state    <= DONE;
              ready_q  <= 1'b1;
              result_o <= {opdata1_i, {WIDTH{1'b1}}};
            end else
`endif
            begin
              state  <= PREP;
              busy_o <= 1'b1;
            end
          end
        end
        PREP: begin
          neg_q  <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_r  <= is_signed & a_q[WIDTH-1];
          opnd_q <= is_div ? b_mag : a_mag;
          acc_hi <= '0;
          acc_lo <= is_div ? a_mag : b_mag;
          cnt    <= CNT_LAST;
          state  <= CALC;
        end
        CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          result_o <= fix_result;
          busy_o   <= 1'b0;
          ready_q  <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          ready_q <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed cases plus random ops against an arithmetic model.
module tb_muldiv_iter;

  localparam int W        = 32;
  localparam int FULL_LAT = W + 3;
`ifdef MD_DIVZERO_FAST_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = W + 3;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          start_i;
  logic [1:0]    op_i;
  logic [W-1:0]  opdata1_i;
  logic [W-1:0]  opdata2_i;
  logic          annul_i;
  logic          busy_o;
  logic          ready_o;
  logic [2*W-1:0] result_o;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] last_result;

  muldiv_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start_i   (start_i),
    .op_i      (op_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .annul_i   (annul_i),
    .busy_o    (busy_o),
    .ready_o   (ready_o),
    .result_o  (result_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero like MIPS DIV.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = sa * sb; return p; end
      2'b01: return {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] corners [5];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input string name,
                       input bit poke_busy, input bit start_in_done);
    int cyc;
    int lat;
    lat = (op[1] && b == 32'd0) ? DZ_LAT : FULL_LAT;
    @(negedge clk);
    start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b;
    @(negedge clk);
    start_i = 1'b0; op_i = 2'($urandom); opdata1_i = $urandom; opdata2_i = $urandom;
    cyc = 1;
    while (ready_o !== 1'b1 && cyc < 200) begin
      checks++;
      if (busy_o !== 1'b1) begin
        errors++;
        $display("FAIL %s busy in cycle %0d: got %b want 1", name, cyc, busy_o);
      end
      start_i = poke_busy && (cyc == 5);
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    checks++;
    if (cyc != lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, cyc, lat);
    end
    checks++;
    if (result_o !== exp) begin
      errors++;
      $display("FAIL %s result: got %h want %h", name, result_o, exp);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s busy with ready: got %b want 0", name, busy_o);
    end
    last_result = exp;
    if (start_in_done) begin
      start_i = 1'b1; op_i = 2'b01; opdata1_i = $urandom; opdata2_i = $urandom;
    end
    @(negedge clk);
    start_i = 1'b0;
    checks++;
    if (ready_o !== 1'b0 || result_o !== exp) begin
      errors++;
      $display("FAIL %s after pulse: got ready=%b res=%h want ready=0 res=%h",
               name, ready_o, result_o, exp);
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || result_o !== exp) begin
      errors++;
      $display("FAIL %s idle hold: got busy=%b res=%h want busy=0 res=%h",
               name, busy_o, result_o, exp);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b1; start_i = 1'b0; annul_i = 1'b0;
    op_i = 2'b00; opdata1_i = '0; opdata2_i = '0;
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== '0) begin
      errors++;
      $display("FAIL reset_async: got busy=%b ready=%b res=%h want 0/0/0", busy_o, ready_o, result_o);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== '0) begin
      errors++;
      $display("FAIL reset_release: got busy=%b ready=%b res=%h want 0/0/0", busy_o, ready_o, result_o);
    end
    last_result = '0;
  endtask

  task automatic test_directed();
    do_op(2'b00, 32'hFFFF_FFFE, 32'h3, 64'hFFFF_FFFF_FFFF_FFFA, "mult_neg", 1'b0, 1'b0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max", 1'b0, 1'b0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD, "div_m7_2", 1'b0, 1'b0);
    do_op(2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E, "divu_100_7", 1'b0, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_ovf", 1'b0, 1'b0);
    do_op(2'b11, 32'h1234, 32'h0, 64'h0000_1234_FFFF_FFFF, "divu_zero", 1'b0, 1'b0);
    do_op(2'b10, 32'hFFFF_FF00, 32'h0, 64'hFFFF_FF00_FFFF_FFFF, "div_zero", 1'b0, 1'b0);
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, "div_7_m2", 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b10; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b want 0", busy_o);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o !== 1'b0 || busy_o !== 1'b0) seen = 1;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_quiet: got activity=%0d want 0", seen);
    end
    checks++;
    if (result_o !== last_result) begin
      errors++;
      $display("FAIL abort_result: got %h want %h", result_o, last_result);
    end
    do_op(2'b01, 32'd3, 32'd5, 64'd15, "multu_after_abort", 1'b0, 1'b0);
  endtask

  task automatic test_annul_late(input int at_cyc, input bit written, input string name);
    logic [31:0] a, b;
    logic [63:0] exp, want;
    int seen;
    a = $urandom; b = $urandom;
    exp = ref_model(2'b01, a, b);
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b01; opdata1_i = a; opdata2_i = b;
    @(negedge clk);
    start_i = 1'b0;
    repeat (at_cyc - 2) @(negedge clk);
    @(posedge clk);
    #1 annul_i = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL %s ready: got %b want 0", name, ready_o);
    end
    @(posedge clk);
    #1 annul_i = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (ready_o !== 1'b0 || busy_o !== 1'b0) seen = 1;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL %s quiet: got activity=%0d want 0", name, seen);
    end
    want = written ? exp : last_result;
    checks++;
    if (result_o !== want) begin
      errors++;
      $display("FAIL %s result: got %h want %h", name, result_o, want);
    end
    last_result = want;
  endtask

  task automatic test_annul_start_idle();
    @(negedge clk);
    start_i = 1'b1; annul_i = 1'b1; op_i = 2'b00; opdata1_i = 32'd9; opdata2_i = 32'd9;
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL annul_start: got busy=%b ready=%b want 0/0", busy_o, ready_o);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b10; opdata1_i = $urandom; opdata2_i = 32'd11;
    @(negedge clk);
    start_i = 1'b0;
    repeat (18) @(negedge clk);
    @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== '0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b ready=%b res=%h want 0/0/0", busy_o, ready_o, result_o);
    end
    @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o !== 1'b0 || busy_o !== 1'b0 || result_o !== '0) seen = 1;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_idle: got activity=%0d want 0", seen);
    end
    last_result = '0;
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = rand_operand();
      b  = rand_operand();
      do_op(op, a, b, ref_model(op, a, b), "random", (i % 7) == 3, (i % 5) == 1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    do_op(2'b11, 32'd1_000_000, 32'd13, ref_model(2'b11, 32'd1_000_000, 32'd13),
          "busy_start_ignored", 1'b1, 1'b0);
    do_op(2'b00, 32'h1357_9BDF, 32'hFFFF_0001, ref_model(2'b00, 32'h1357_9BDF, 32'hFFFF_0001),
          "done_start_ignored", 1'b0, 1'b1);
    test_abort();
    test_annul_late(FULL_LAT - 1, 1'b0, "annul_fix");
    test_annul_late(FULL_LAT, 1'b1, "annul_done");
    test_annul_start_idle();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
